// File: rtl/output_collector.sv
// ---------------------------------------------------------------------------
// output_collector
//
// Purpose:
//   Receiving end of the controller's output-marking interface. Each
//   output_valid pulse is captured with its coordinates and accumulation word
//   into a small FIFO. The FIFO head is presented as a valid/ready stream.
//   The block checks arrival order against the controller's loop order
//   (channel innermost, then y, then x). It raises sticky flags for dropped
//   and stray outputs. It pulses done once the whole tensor has been
//   received and drained.
//
// Ports:
//   clk                  - single clock, rising edge
//   arst_n_in            - asynchronous active-low reset
//   start                - arms a new run (only honoured in IDLE)
//   output_valid         - one-cycle pulse marking a finished output
//   output_x/_y/_ch      - coordinates of that output
//   output_data          - accumulation word aligned with output_valid
//   out_valid/out_ready  - stream handshake towards the consumer
//   out_data/_x/_y/_ch   - head FIFO entry, zero while the FIFO is empty
//   collecting           - high in COLLECT and DRAIN
//   done                 - one-cycle pulse when the run is complete
//   overflow             - sticky, an output was dropped on a full FIFO
//   order_error          - sticky, coordinates differed from expected order
//   stray_output         - sticky, output_valid seen outside COLLECT
//   outputs_received     - saturating count of pulses accepted in COLLECT
// ---------------------------------------------------------------------------
module output_collector #(
  parameter int ACCUMULATION_WIDTH = 32,
  parameter int FEATURE_MAP_WIDTH  = 1024,
  parameter int FEATURE_MAP_HEIGHT = 1024,
  parameter int OUTPUT_NB_CHANNELS = 64,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic                          clk,
  input  logic                          arst_n_in,
  input  logic                          start,
  input  logic                          output_valid,
  input  logic [31:0]                   output_x,
  input  logic [31:0]                   output_y,
  input  logic [31:0]                   output_ch,
  input  logic [ACCUMULATION_WIDTH-1:0] output_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ACCUMULATION_WIDTH-1:0] out_data,
  output logic [31:0]                   out_x,
  output logic [31:0]                   out_y,
  output logic [31:0]                   out_ch,
  output logic                          collecting,
  output logic                          done,
  output logic                          overflow,
  output logic                          order_error,
  output logic                          stray_output,
  output logic [31:0]                   outputs_received
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [31:0] LAST_IDX =
    32'(FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS - 1);
  localparam logic [31:0] LAST_X  = 32'(FEATURE_MAP_WIDTH - 1);
  localparam logic [31:0] LAST_Y  = 32'(FEATURE_MAP_HEIGHT - 1);
  localparam logic [31:0] LAST_CH = 32'(OUTPUT_NB_CHANNELS - 1);

  logic [1:0]  r_state;
  logic [AW:0] r_wrPtr;
  logic [AW:0] r_rdPtr;
  logic [31:0] r_expX;
  logic [31:0] r_expY;
  logic [31:0] r_expCh;
  logic [31:0] r_received;
  logic        r_overflow;
  logic        r_orderError;
  logic        r_stray;

  logic [ACCUMULATION_WIDTH-1:0] r_memData [FIFO_DEPTH];
  logic [31:0]                   r_memX    [FIFO_DEPTH];
  logic [31:0]                   r_memY    [FIFO_DEPTH];
  logic [31:0]                   r_memCh   [FIFO_DEPTH];

  logic        w_empty;
  logic        w_full;
  logic        w_pop;
  logic        w_start;
  logic        w_pushReq;
  logic        w_store;
  logic        w_mismatch;
  logic        w_lastPush;
  logic [31:0] w_nextX;
  logic [31:0] w_nextY;
  logic [31:0] w_nextCh;

  // Extra pointer MSB distinguishes full (MSBs differ) from empty (equal).
  assign w_empty    = (r_wrPtr == r_rdPtr);
  assign w_full     = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                      (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_pop      = !w_empty && out_ready;
  assign w_start    = (r_state == S_IDLE) && start;
  assign w_pushReq  = (r_state == S_COLLECT) && output_valid;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_store    = w_pushReq && (!w_full || w_pop);
  assign w_mismatch = (output_x != r_expX) || (output_y != r_expY) ||
                      (output_ch != r_expCh);
  assign w_lastPush = w_pushReq && (r_received == LAST_IDX);

  // Expected coordinates: channel innermost, then y, then x, each wrapping.
  always_comb begin
    w_nextX  = r_expX;
    w_nextY  = r_expY;
    w_nextCh = r_expCh + 32'd1;
    if (r_expCh == LAST_CH) begin
      w_nextCh = 32'd0;
      w_nextY  = r_expY + 32'd1;
      if (r_expY == LAST_Y) begin
        w_nextY = 32'd0;
        w_nextX = (r_expX == LAST_X) ? 32'd0 : r_expX + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (start) r_state <= S_COLLECT;
        S_COLLECT: if (w_lastPush) r_state <= S_DRAIN;
        S_DRAIN:   if (w_empty) r_state <= S_DONE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else if (w_start) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_store) r_wrPtr <= r_wrPtr + (AW+1)'(1);
      if (w_pop)   r_rdPtr <= r_rdPtr + (AW+1)'(1);
    end
  end

  // Storage is deliberately not reset; outputs are gated by out_valid.
  always_ff @(posedge clk) begin
    if (w_store) begin
      r_memData[r_wrPtr[AW-1:0]] <= output_data;
      r_memX[r_wrPtr[AW-1:0]]    <= output_x;
      r_memY[r_wrPtr[AW-1:0]]    <= output_y;
      r_memCh[r_wrPtr[AW-1:0]]   <= output_ch;
    end
  end

  // Counters advance on every pulse in COLLECT, stored or dropped.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      r_expX       <= '0;
      r_expY       <= '0;
      r_expCh      <= '0;
      r_received   <= '0;
      r_overflow   <= 1'b0;
      r_orderError <= 1'b0;
      r_stray      <= 1'b0;
    end else if (w_start) begin
      r_expX       <= '0;
      r_expY       <= '0;
      r_expCh      <= '0;
      r_received   <= '0;
      r_overflow   <= 1'b0;
      r_orderError <= 1'b0;
      r_stray      <= 1'b0;
    end else begin
      if (w_pushReq) begin
        r_expX  <= w_nextX;
        r_expY  <= w_nextY;
        r_expCh <= w_nextCh;
        if (r_received != 32'hFFFF_FFFF) r_received <= r_received + 32'd1;
        if (w_mismatch) r_orderError <= 1'b1;
        if (!w_store)   r_overflow   <= 1'b1;
      end
      if (output_valid && (r_state != S_COLLECT)) r_stray <= 1'b1;
    end
  end

  assign out_valid        = !w_empty;
  assign out_data         = out_valid ? r_memData[r_rdPtr[AW-1:0]] : '0;
  assign out_x            = out_valid ? r_memX[r_rdPtr[AW-1:0]]    : '0;
  assign out_y            = out_valid ? r_memY[r_rdPtr[AW-1:0]]    : '0;
  assign out_ch           = out_valid ? r_memCh[r_rdPtr[AW-1:0]]   : '0;
  assign collecting       = (r_state == S_COLLECT) || (r_state == S_DRAIN);
  assign done             = (r_state == S_DONE);
  assign overflow         = r_overflow;
  assign order_error      = r_orderError;
  assign stray_output     = r_stray;
  assign outputs_received = r_received;

endmodule
